// File: rtl/match_ctrl.sv
// match_ctrl: pong match sequencer owning scores, freeze timing, ball recentring, serve side and rally speed.
// Optional macro WIN_BY_TWO_EN enables deuce play (win needs a 2-point lead, scores rebase near overflow).
module match_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SPEED_W      = 4,
    parameter int FREEZE_W     = 17,
    parameter int POINT_FREEZE = 8000,
    parameter int GAME_FREEZE  = 131071,
    parameter int RAMP_HITS    = 4
) (
    input  logic               game_clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SPEED_W-1:0] difficulty,
    input  logic               out_left,
    input  logic               out_right,
    input  logic               paddle_hit,
    output logic [SPEED_W-1:0] speed,
    output logic               ball_reset,
    output logic               serve_right,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic               frozen
);

    localparam logic ST_FREEZE = 1'b0;
    localparam logic ST_PLAY   = 1'b1;
    localparam int   HITS_W    = (RAMP_HITS > 1) ? $clog2(RAMP_HITS) : 1;
    localparam int   HITS_LAST = (RAMP_HITS > 0) ? RAMP_HITS - 1 : 0;

    localparam logic [SPEED_W-1:0]  SPEED_MAX  = {SPEED_W{1'b1}};
    localparam logic [SCORE_W-1:0]  WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [FREEZE_W-1:0] CNT_GAME   = FREEZE_W'(GAME_FREEZE);
    localparam logic [FREEZE_W-1:0] CNT_POINT  = FREEZE_W'(POINT_FREEZE);
    localparam logic [FREEZE_W-1:0] CNT_ONE    = FREEZE_W'(1);
    localparam logic [HITS_W-1:0]   HITS_LAST_V = HITS_W'(HITS_LAST);

    logic                state_r, state_nxt_s;
    logic [FREEZE_W-1:0] cnt_r, cnt_nxt_s;
    logic [SCORE_W-1:0]  score_p1_r, score_p1_nxt_s, score_p2_r, score_p2_nxt_s;
    logic [SPEED_W-1:0]  speed_r, speed_nxt_s, base_r, base_nxt_s, ramp_r, ramp_nxt_s;
    logic [HITS_W-1:0]   hits_r, hits_nxt_s;
    logic                ball_reset_r, ball_reset_nxt_s, serve_right_r, serve_right_nxt_s;
    logic [1:0]          winner_r, winner_nxt_s;
    logic [SCORE_W-1:0]  scorer_s, other_s, scorer_new_s, other_new_s;
    logic                won_s;

    function automatic logic [SPEED_W-1:0] speed_sum(input logic [SPEED_W-1:0] a,
                                                     input logic [SPEED_W-1:0] b);
        logic [SPEED_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SPEED_W]) begin
            speed_sum = SPEED_MAX;
        end else begin
            speed_sum = sum[SPEED_W-1:0];
        end
    endfunction

    // Next-state decode: freeze countdown, rally ramp and point scoring
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        score_p1_nxt_s    = score_p1_r;
        score_p2_nxt_s    = score_p2_r;
        speed_nxt_s       = speed_r;
        base_nxt_s        = base_r;
        ramp_nxt_s        = ramp_r;
        hits_nxt_s        = hits_r;
        ball_reset_nxt_s  = 1'b0;
        serve_right_nxt_s = serve_right_r;
        winner_nxt_s      = winner_r;
        scorer_s          = out_left ? score_p1_r : score_p2_r;
        other_s           = out_left ? score_p2_r : score_p1_r;
`ifdef WIN_BY_TWO_EN
        scorer_new_s = scorer_s + SCORE_W'(1);
        won_s        = (scorer_new_s >= WIN_S) &&
                       ({1'b0, scorer_new_s} >= ({1'b0, other_s} + (SCORE_W+1)'(2)));
        // Rebase both scores one step down before the scorer hits all-ones; the lead is unchanged
        if (scorer_new_s == {SCORE_W{1'b1}}) begin
            scorer_new_s = scorer_s;
            other_new_s  = (other_s != {SCORE_W{1'b0}}) ? other_s - SCORE_W'(1) : other_s;
        end else begin
            other_new_s  = other_s;
        end
`else
        scorer_new_s = (scorer_s == {SCORE_W{1'b1}}) ? scorer_s : scorer_s + SCORE_W'(1);
        other_new_s  = other_s;
        won_s        = (scorer_new_s == WIN_S);
`endif
        case (state_r)
            ST_FREEZE: begin
                speed_nxt_s = {SPEED_W{1'b0}};
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s      = ST_PLAY;
                    ball_reset_nxt_s = 1'b1;
                    base_nxt_s       = difficulty;
                    ramp_nxt_s       = {SPEED_W{1'b0}};
                    hits_nxt_s       = {HITS_W{1'b0}};
                    speed_nxt_s      = difficulty;
                    if (winner_r != 2'b00) begin
                        score_p1_nxt_s = {SCORE_W{1'b0}};
                        score_p2_nxt_s = {SCORE_W{1'b0}};
                        winner_nxt_s   = 2'b00;
                    end else begin
                        winner_nxt_s   = winner_r;
                    end
                end else if (start) begin
                    cnt_nxt_s = CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_PLAY: begin
                if (out_left || out_right) begin
                    state_nxt_s = ST_FREEZE;
                    speed_nxt_s = {SPEED_W{1'b0}};
                    cnt_nxt_s   = won_s ? CNT_GAME : CNT_POINT;
                    if (out_left) begin
                        score_p1_nxt_s    = scorer_new_s;
                        score_p2_nxt_s    = other_new_s;
                        serve_right_nxt_s = 1'b0;
                        winner_nxt_s      = won_s ? 2'b01 : winner_r;
                    end else begin
                        score_p2_nxt_s    = scorer_new_s;
                        score_p1_nxt_s    = other_new_s;
                        serve_right_nxt_s = 1'b1;
                        winner_nxt_s      = won_s ? 2'b10 : winner_r;
                    end
                end else begin
                    if (paddle_hit && (RAMP_HITS != 0)) begin
                        if (hits_r == HITS_LAST_V) begin
                            hits_nxt_s = {HITS_W{1'b0}};
                            ramp_nxt_s = (ramp_r == SPEED_MAX) ? ramp_r : ramp_r + SPEED_W'(1);
                        end else begin
                            hits_nxt_s = hits_r + HITS_W'(1);
                        end
                    end else begin
                        hits_nxt_s = hits_r;
                    end
                    speed_nxt_s = speed_sum(base_r, ramp_nxt_s);
                end
            end
            default: begin
                state_nxt_s = ST_FREEZE;
                cnt_nxt_s   = CNT_GAME;
                speed_nxt_s = {SPEED_W{1'b0}};
            end
        endcase
    end

    // Match state registers with asynchronous active-low reset
    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_FREEZE;
            cnt_r         <= CNT_GAME;
            score_p1_r    <= {SCORE_W{1'b0}};
            score_p2_r    <= {SCORE_W{1'b0}};
            speed_r       <= {SPEED_W{1'b0}};
            base_r        <= {SPEED_W{1'b0}};
            ramp_r        <= {SPEED_W{1'b0}};
            hits_r        <= {HITS_W{1'b0}};
            ball_reset_r  <= 1'b1;
            serve_right_r <= 1'b0;
            winner_r      <= 2'b00;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            score_p1_r    <= score_p1_nxt_s;
            score_p2_r    <= score_p2_nxt_s;
            speed_r       <= speed_nxt_s;
            base_r        <= base_nxt_s;
            ramp_r        <= ramp_nxt_s;
            hits_r        <= hits_nxt_s;
            ball_reset_r  <= ball_reset_nxt_s;
            serve_right_r <= serve_right_nxt_s;
            winner_r      <= winner_nxt_s;
        end
    end

    assign speed       = speed_r;
    assign ball_reset  = ball_reset_r;
    assign serve_right = serve_right_r;
    assign score_p1    = score_p1_r;
    assign score_p2    = score_p2_r;
    assign winner      = winner_r;
    assign frozen      = (state_r == ST_FREEZE);

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed match scenarios plus random rallies against a rule-level model.
// Freeze lengths are shortened through parameters so whole games fit in a short run.
module tb_match_ctrl;

    localparam int GF = 40;
    localparam int PF = 12;

    logic       game_clk   = 1'b0;
    logic       reset_n    = 1'b1;
    logic       start      = 1'b0;
    logic [3:0] difficulty = 4'd0;
    logic       out_left   = 1'b0;
    logic       out_right  = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [3:0] speed;
    logic       ball_reset;
    logic       serve_right;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic       frozen;

    match_ctrl #(.GAME_FREEZE(GF), .POINT_FREEZE(PF)) dut (
        .game_clk   (game_clk),
        .reset_n    (reset_n),
        .start      (start),
        .difficulty (difficulty),
        .out_left   (out_left),
        .out_right  (out_right),
        .paddle_hit (paddle_hit),
        .speed      (speed),
        .ball_reset (ball_reset),
        .serve_right(serve_right),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .frozen     (frozen)
    );

    always #5 game_clk = ~game_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Rule-level model: playing flag, freeze cycles left, scores, total hits in the current rally
    int m_play, m_left, m_p1, m_p2, m_serve, m_win, m_base, m_hits, m_br;

    function automatic int exp_speed();
        int s;
        if (m_play == 0) return 0;
        s = m_base + m_hits / 4;
        return (s > 15) ? 15 : s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".speed"},       speed,       exp_speed());
        chk({tag, ".ball_reset"},  ball_reset,  m_br);
        chk({tag, ".serve_right"}, serve_right, m_serve);
        chk({tag, ".score_p1"},    score_p1,    m_p1);
        chk({tag, ".score_p2"},    score_p2,    m_p2);
        chk({tag, ".winner"},      winner,      m_win);
        chk({tag, ".frozen"},      frozen,      (m_play == 0) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_play = 0; m_left = GF; m_p1 = 0; m_p2 = 0;
        m_serve = 0; m_win = 0; m_base = 0; m_hits = 0; m_br = 1;
    endtask

    task automatic model_point(input bit left);
        int s, o, n;
        bit won;
        s = left ? m_p1 : m_p2;
        o = left ? m_p2 : m_p1;
`ifdef WIN_BY_TWO_EN
        n = s + 1;
        won = (n >= 9) && (n - o >= 2);
        if (n == 15) begin
            n = s;
            if (o > 0) o = o - 1;
        end
`else
        n = (s + 1 > 15) ? 15 : s + 1;
        won = (n == 9);
`endif
        if (left) begin
            m_p1 = n; m_p2 = o; m_serve = 0;
            if (won) m_win = 1;
        end else begin
            m_p2 = n; m_p1 = o; m_serve = 1;
            if (won) m_win = 2;
        end
        m_play = 0;
        m_left = won ? GF : PF;
    endtask

    task automatic model_step(input bit st, input bit ol, input bit orr, input bit ph, input int diff);
        m_br = 0;
        if (m_play == 0) begin
            if (m_left == 1) begin
                m_play = 1; m_br = 1; m_base = diff; m_hits = 0;
                if (m_win != 0) begin
                    m_p1 = 0; m_p2 = 0; m_win = 0;
                end
            end else begin
                m_left = st ? 1 : m_left - 1;
            end
        end else if (ol || orr) begin
            model_point(ol);
        end else if (ph) begin
            m_hits++;
        end
    endtask

    task automatic tick(input bit st, input bit ol, input bit orr, input bit ph);
        start = st; out_left = ol; out_right = orr; paddle_hit = ph;
        @(posedge game_clk);
        model_step(st, ol, orr, ph, difficulty);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        @(posedge game_clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic get_play(input bit st, input int bound);
        for (int i = 0; i < bound && m_play == 0; i++) tick(st, 1'b0, 1'b0, 1'b0);
        chk("play_reached", frozen, 0);
    endtask

    initial begin
        int n;
        #2;
        // Power-up freeze and first serve
        difficulty = 4'd3;
        do_reset();
        n = 0;
        while (frozen && n < GF + 20) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("game_freeze_len", n, GF);
        // Difficulty ramp within a rally
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ramp_speed", speed, 5);
        // Left-edge point and start cutting the point freeze
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("p1_point", score_p1, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("start_cut", frozen, 0);
        // Base speed at the ceiling stays saturated
        difficulty = 4'd15;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        get_play(1'b1, 10);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_speed", speed, 15);
        // Simultaneous edges: left wins
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("both_out_p2", score_p2, 1);
        get_play(1'b1, 10);
        // Random rallies across several games
        for (int i = 0; i < 3000; i++) begin
            difficulty = 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
        end
        // Game point at 8:8
        difficulty = 4'd6;
        do_reset();
        get_play(1'b1, 10);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            get_play(1'b1, 10);
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            get_play(1'b1, 10);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef WIN_BY_TWO_EN
        chk("deuce_no_win", winner, 0);
        get_play(1'b1, 10);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
`endif
        chk("win_p1", winner, 1);
        n = 0;
        while (frozen && n < GF + 20) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("won_freeze_len", n, GF);
        chk("won_clear_p1", score_p1, 0);
        // Reset mid-rally at 5:3
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            get_play(1'b1, 10);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0);
            get_play(1'b1, 10);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_p1", score_p1, 5);
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
